prco_encoder: RTL and testbench

//  Producer side of the PRCO 16-bit instruction word. Accepts decoded instruction fields
//  (op/seld/sela/imm8/simm5) over a valid/ready handshake, packs them into the word layout
//  the core's decoder consumes, and buffers them in a small FIFO.

---
 rtl/prco_encoder.sv | 131 +++++++++++++
 tb/tb_prco_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prco_encoder.sv
// PRCO instruction-word producer: packs decoded fields into 16-bit words, buffers them
// in a small FIFO and streams them to instruction memory at sequential addresses.
module prco_encoder #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              q_ready,
  input  logic [4:0]        i_op,
  input  logic [2:0]        i_seld,
  input  logic [2:0]        i_sela,
  input  logic [7:0]        i_imm8,
  input  logic [4:0]        i_simm5,
  output logic              q_mem_we,
  input  logic              i_mem_stall,
  output logic [ADDR_W-1:0] q_mem_addr,
  output logic [15:0]       q_mem_data,
  output logic              q_err,
  output logic [7:0]        q_err_count,
  output logic              q_wrap
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_MOVI = 5'h01;
  localparam logic [4:0] OP_MOV  = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  function automatic logic legal_op(input logic [4:0] op);
    return (op == OP_NOP) || (op == OP_MOVI) || (op == OP_MOV) || (op == OP_ADD);
  endfunction

  function automatic logic [15:0] pack_word(input logic [4:0] op, input logic [2:0] seld,
                                            input logic [2:0] sela, input logic [7:0] imm8,
                                            input logic [4:0] simm5);
    logic [15:0] w;
    w = {op, 11'b0};
    if (op == OP_MOVI)
      w = {op, seld, imm8};
    else if ((op == OP_MOV) || (op == OP_ADD))
      w = {op, seld, sela, simm5};
    return w;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             is_legal, accept, push, pop, wr_done;
  logic [15:0]      packed_word;
  state_t           state;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign is_legal    = legal_op(i_op);
  assign packed_word = pack_word(i_op, i_seld, i_sela, i_imm8, i_simm5);
  assign q_ready     = !i_reset && i_en && !i_flush && !fifo_full;
  assign accept      = i_valid && q_ready;
  assign push        = accept && is_legal;
  assign wr_done     = (state == S_WRITE) && i_en && !i_mem_stall;
  assign pop         = !i_flush && i_en && !fifo_empty && ((state == S_IDLE) || wr_done);

  always_ff @(posedge i_clk) begin
    if (push)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= packed_word;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= S_IDLE;
      q_mem_we    <= 1'b0;
      q_mem_data  <= '0;
      q_mem_addr  <= BASE;
      q_err       <= 1'b0;
      q_err_count <= '0;
      q_wrap      <= 1'b0;
    end else begin
      q_err <= accept && !is_legal;
      if (accept && !is_legal)
        q_err_count <= sat_inc8(q_err_count);

      if (i_flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        state      <= S_IDLE;
        q_mem_we   <= 1'b0;
        q_mem_addr <= BASE;
        q_wrap     <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;

        if (wr_done) begin
          q_mem_addr <= q_mem_addr + 1'b1;
          if (&q_mem_addr)
            q_wrap <= 1'b1;
        end

        // A completing write with more data queued chains straight into the next one.
        if (pop) begin
          q_mem_data <= fifo_mem[rd_ptr[PTR_W-1:0]];
          q_mem_we   <= 1'b1;
          state      <= S_WRITE;
        end else if (wr_done) begin
          q_mem_we   <= 1'b0;
          state      <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prco_encoder.sv
// Directed bench for prco_encoder (ADDR_W=4 so address wrap is reachable quickly).
module tb_prco_encoder;

  logic        i_clk = 1'b0;
  logic        i_reset, i_en, i_flush, i_valid, i_mem_stall;
  logic        q_ready, q_mem_we, q_err, q_wrap;
  logic [4:0]  i_op, i_simm5;
  logic [2:0]  i_seld, i_sela;
  logic [7:0]  i_imm8, q_err_count;
  logic [3:0]  q_mem_addr;
  logic [15:0] q_mem_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  int model_addr = 0;

  prco_encoder #(.FIFO_DEPTH(4), .ADDR_W(4), .BASE_ADDR(0)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_flush(i_flush),
    .i_valid(i_valid), .q_ready(q_ready), .i_op(i_op), .i_seld(i_seld),
    .i_sela(i_sela), .i_imm8(i_imm8), .i_simm5(i_simm5), .q_mem_we(q_mem_we),
    .i_mem_stall(i_mem_stall), .q_mem_addr(q_mem_addr), .q_mem_data(q_mem_data),
    .q_err(q_err), .q_err_count(q_err_count), .q_wrap(q_wrap)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  seld;
    logic [2:0]  sela;
    logic [7:0]  imm8;
    logic [4:0]  simm5;
    logic        legal;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completed memory write must match the next expected word and address.
  always @(negedge i_clk) begin
    if (!i_reset && q_mem_we && !i_mem_stall && i_en && !i_flush) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got data %h addr %0d, expected no write", q_mem_data, q_mem_addr);
      end else begin
        chk("write_data", 32'(q_mem_data), 32'(exp_q[0]));
        chk("write_addr", 32'(q_mem_addr), 32'(model_addr));
        void'(exp_q.pop_front());
        model_addr = (model_addr + 1) % 16;
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [2:0] sd, input logic [2:0] sa,
                      input logic [7:0] im, input logic [4:0] s5);
    i_op = op; i_seld = sd; i_sela = sa; i_imm8 = im; i_simm5 = s5; i_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge i_clk);
      if (q_ready) begin
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL send_timeout: got q_ready 0 for 100 cycles, expected 1");
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0 && !q_mem_we) return;
      @(posedge i_clk); #1;
    end
    n_checks++; n_errors++;
    $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    exp_q.delete();
    model_addr = 0;
  endtask

  logic [7:0] prev_cnt;
  int idx;
  logic acc;

  initial begin
    tbl[0] = '{5'h01, 3'd3, 3'd0, 8'h5A, 5'h00, 1'b1, 16'h0B5A};
    tbl[1] = '{5'h03, 3'd1, 3'd2, 8'h00, 5'h1D, 1'b1, 16'h195D};
    tbl[2] = '{5'h00, 3'd7, 3'd7, 8'hFF, 5'h1F, 1'b1, 16'h0000};
    tbl[3] = '{5'h1F, 3'd1, 3'd1, 8'h11, 5'h01, 1'b0, 16'h0000};
    tbl[4] = '{5'h02, 3'd5, 3'd6, 8'hAA, 5'h0F, 1'b1, 16'h15CF};
    tbl[5] = '{5'h01, 3'd7, 3'd4, 8'h00, 5'h15, 1'b1, 16'h0F00};
    tbl[6] = '{5'h03, 3'd0, 3'd7, 8'h33, 5'h10, 1'b1, 16'h18F0};
    tbl[7] = '{5'h04, 3'd2, 3'd3, 8'h44, 5'h02, 1'b0, 16'h0000};

    i_reset = 1'b1; i_en = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_mem_stall = 1'b0;
    i_op = '0; i_seld = '0; i_sela = '0; i_imm8 = '0; i_simm5 = '0;
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("rst_ready", 32'(q_ready), 0);
    chk("rst_we", 32'(q_mem_we), 0);
    chk("rst_addr", 32'(q_mem_addr), 0);
    chk("rst_data", 32'(q_mem_data), 0);
    chk("rst_errcnt", 32'(q_err_count), 0);
    i_reset = 1'b0;
    #1 chk("ready_after_rst", 32'(q_ready), 1);

    // Single MOVI: exact latency and a one-cycle write.
    exp_q.push_back(16'h0B5A);
    send(5'h01, 3'd3, 3'd0, 8'h5A, 5'h00);
    chk("movi_latency_we0", 32'(q_mem_we), 0);
    @(posedge i_clk); #1;
    chk("movi_we", 32'(q_mem_we), 1);
    chk("movi_addr", 32'(q_mem_addr), 0);
    chk("movi_data", 32'(q_mem_data), 32'h0B5A);
    @(posedge i_clk); #1;
    chk("movi_we_drop", 32'(q_mem_we), 0);
    drain();

    // ADD then NOP back to back.
    do_flush();
    exp_q.push_back(16'h195D);
    exp_q.push_back(16'h0000);
    send(5'h03, 3'd1, 3'd2, 8'h00, 5'h1D);
    send(5'h00, 3'd0, 3'd0, 8'h00, 5'h00);
    chk("add_we", 32'(q_mem_we), 1);
    chk("add_data", 32'(q_mem_data), 32'h195D);
    chk("add_addr", 32'(q_mem_addr), 0);
    @(posedge i_clk); #1;
    chk("nop_b2b_we", 32'(q_mem_we), 1);
    chk("nop_data", 32'(q_mem_data), 32'h0000);
    chk("nop_addr", 32'(q_mem_addr), 1);
    drain();

    // Table of packing and illegal-opcode vectors.
    do_flush();
    for (int v = 0; v < 8; v++) begin
      prev_cnt = q_err_count;
      if (tbl[v].legal) exp_q.push_back(tbl[v].exp);
      send(tbl[v].op, tbl[v].seld, tbl[v].sela, tbl[v].imm8, tbl[v].simm5);
      chk("err_pulse", 32'(q_err), 32'(!tbl[v].legal));
      chk("err_count", 32'(q_err_count), 32'(prev_cnt + (tbl[v].legal ? 8'd0 : 8'd1)));
      if (!tbl[v].legal) begin
        chk("ready_after_illegal", 32'(q_ready), 1);
        @(posedge i_clk); #1;
        chk("err_single_pulse", 32'(q_err), 0);
      end
      drain();
    end

    // Stall held: 4 in FIFO + 1 in output register, then q_ready drops.
    do_flush();
    i_mem_stall = 1'b1;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      i_op = 5'h01; i_seld = idx[2:0]; i_imm8 = 8'(8'h10 + idx); i_valid = (idx < 6);
      @(negedge i_clk);
      acc = i_valid && q_ready;
      @(posedge i_clk); #1;
      if (acc) begin
        exp_q.push_back(16'(16'h0800 + (idx << 8) + 16'h10 + idx));
        idx++;
      end
    end
    i_valid = 1'b0;
    chk("stall_accepted", 32'(idx), 5);
    chk("stall_ready_low", 32'(q_ready), 0);
    chk("stall_we_held", 32'(q_mem_we), 1);
    chk("stall_data_held", 32'(q_mem_data), 32'h0810);
    chk("stall_addr_held", 32'(q_mem_addr), 0);
    i_mem_stall = 1'b0;
    exp_q.push_back(16'h0D15);
    send(5'h01, 3'd5, 3'd0, 8'h15, 5'h00);
    drain();
    chk("stall_all_written", 32'(q_mem_addr), 6);

    // Address wrap with ADDR_W=4.
    do_flush();
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(16'(16'h0800 + i));
      send(5'h01, 3'd0, 3'd0, 8'(i), 5'h00);
    end
    drain();
    chk("prewrap_addr", 32'(q_mem_addr), 15);
    chk("prewrap_flag", 32'(q_wrap), 0);
    for (int i = 15; i < 17; i++) begin
      exp_q.push_back(16'(16'h0800 + i));
      send(5'h01, 3'd0, 3'd0, 8'(i), 5'h00);
    end
    drain();
    chk("wrap_flag", 32'(q_wrap), 1);
    chk("wrap_addr", 32'(q_mem_addr), 1);

    // Flush mid-write with a tuple presented in the same cycle.
    prev_cnt = q_err_count;
    i_mem_stall = 1'b1;
    exp_q.push_back(16'h0877);
    send(5'h01, 3'd0, 3'd0, 8'h77, 5'h00);
    @(posedge i_clk); #1;
    chk("pre_flush_we", 32'(q_mem_we), 1);
    i_op = 5'h01; i_imm8 = 8'h99; i_valid = 1'b1;
    do_flush();
    i_valid = 1'b0;
    chk("flush_we", 32'(q_mem_we), 0);
    chk("flush_addr", 32'(q_mem_addr), 0);
    chk("flush_wrap", 32'(q_wrap), 0);
    chk("flush_errcnt_kept", 32'(q_err_count), 32'(prev_cnt));
    i_mem_stall = 1'b0;
    repeat (5) @(posedge i_clk);
    #1 chk("flush_no_write", 32'(q_mem_we), 0);

    // Asynchronous reset in the middle of a stalled write.
    i_mem_stall = 1'b1;
    exp_q.push_back(16'h0B5A);
    send(5'h01, 3'd3, 3'd0, 8'h5A, 5'h00);
    send(5'h01, 3'd3, 3'd0, 8'h5A, 5'h00);
    chk("mid_write_we", 32'(q_mem_we), 1);
    #2 i_reset = 1'b1;
    #1;
    chk("async_rst_we", 32'(q_mem_we), 0);
    chk("async_rst_data", 32'(q_mem_data), 0);
    chk("async_rst_addr", 32'(q_mem_addr), 0);
    chk("async_rst_err", 32'(q_err), 0);
    chk("async_rst_errcnt", 32'(q_err_count), 0);
    chk("async_rst_wrap", 32'(q_wrap), 0);
    chk("async_rst_ready", 32'(q_ready), 0);
    exp_q.delete();
    model_addr = 0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_mem_stall = 1'b0;
    repeat (4) @(posedge i_clk);
    #1 chk("post_rst_fifo_empty", 32'(q_mem_we), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
